// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and default datapath widths.
// Used by the ALU control stage and by the execute stage.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int SHAMT_W    = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SRL = 4'd6
    } alu_op_e;

    // Codes above ALU_SRL are reserved and reported as illegal.
    function automatic logic is_legal_op(input logic [3:0] sel);
        return sel <= 4'(ALU_SRL);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Handshake bundle between the ALU control stage, the execute stage and EX/MEM.
// master = the side issuing operations and consuming results; slave = ex_stage.
interface ex_stage_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         alu_sel;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [SHAMT_W-1:0] shamt;
    logic [REG_W-1:0]   rd_in;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_result;
    logic               out_zero;
    logic [REG_W-1:0]   out_rd;
    logic               out_illegal;

    modport master (
        output in_valid, alu_sel, op_a, op_b, shamt, rd_in, flush, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, alu_sel, op_a, op_b, shamt, rd_in, flush, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: one result per operation code, reserved codes flagged.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]         i_alu_sel,
    input  logic [DATA_W-1:0]  i_op_a,
    input  logic [DATA_W-1:0]  i_op_b,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [DATA_W-1:0]  o_result,
    output logic               o_illegal
);

    // Select the result for the requested operation.
    always_comb begin
        // NOTE: defaults assigned first so every path drives both outputs (no latch).
        o_result  = '0;
        o_illegal = 1'b0;
        case (alu_op_e'(i_alu_sel))
            ALU_ADD: o_result = i_op_a + i_op_b;
            ALU_SUB: o_result = i_op_a - i_op_b;
            ALU_AND: o_result = i_op_a & i_op_b;
            ALU_OR:  o_result = i_op_a | i_op_b;
            ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
            ALU_XOR: o_result = i_op_a ^ i_op_b;
            ALU_SRL: o_result = i_op_b >> i_shamt;
            default: o_illegal = !is_legal_op(i_alu_sel);
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU result computed at the input, held in an output register
// backed by a one-entry skid register so in_ready can be a plain flop.
module ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    ex_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              illegal;
        logic [REG_W-1:0]  rd;
    } entry_t;

    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_illegal;
    entry_t            w_new;
    logic              w_accept;
    logic              w_drain;

    entry_t r_out;
    entry_t r_skid;
    logic   r_out_valid;
    logic   r_in_ready;   // also the "skid empty" flag

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .i_alu_sel (bus.alu_sel),
        .i_op_a    (bus.op_a),
        .i_op_b    (bus.op_b),
        .i_shamt   (bus.shamt),
        .o_result  (w_alu_result),
        .o_illegal (w_alu_illegal)
    );

    assign w_new    = '{result: w_alu_result, illegal: w_alu_illegal, rd: bus.rd_in};
    assign w_accept = bus.in_valid && r_in_ready;
    assign w_drain  = r_out_valid && bus.out_ready;

    // Output register and handshake state; reset beats flush beats transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out       <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (!r_out_valid || w_drain) begin
            if (!r_in_ready) begin
                r_out       <= r_skid;
                r_out_valid <= 1'b1;
                r_in_ready  <= 1'b1;
            end else if (w_accept) begin
                r_out       <= w_new;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_in_ready <= 1'b0;
        end
    end

    // Skid payload: captured when an accept meets a stalled output register.
    always_ff @(posedge clk) begin
        // NOTE: payload has no reset; its validity is carried by r_in_ready, which is reset.
        if (w_accept && r_out_valid && !bus.out_ready) begin
            r_skid <= w_new;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_out.result;
    assign bus.out_zero    = (r_out.result == '0);
    assign bus.out_rd      = r_out.rd;
    assign bus.out_illegal = r_out.illegal;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: table of single ALU ops, directed stall /
// flush / reset sequences, then random traffic against a queue-based model.
module tb_ex_stage;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();

    ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [DW-1:0] result;
        logic          illegal;
        logic [RW-1:0] rd;
    } exp_t;

    typedef struct {
        logic [3:0]    sel;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [4:0]    sh;
        logic [DW-1:0] res;
        logic          ill;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];
    exp_t model_q [$];
    exp_t hd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock; outputs are then read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.alu_sel   = 4'd0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.shamt     = '0;
        bus.rd_in     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic offer(input logic [3:0] sel, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] sh, input logic [RW-1:0] rd);
        bus.in_valid = 1'b1;
        bus.alu_sel  = sel;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.shamt    = sh;
        bus.rd_in    = rd;
    endtask

    // Reference ALU written from the operation definitions.
    function automatic exp_t alu_ref(input logic [3:0] sel, input logic [DW-1:0] a,
                                     input logic [DW-1:0] b, input logic [4:0] sh,
                                     input logic [RW-1:0] rd);
        exp_t e;
        int   sa;
        int   sb;
        sa = a;
        sb = b;
        e.rd = rd;
        e.illegal = 1'b0;
        case (sel)
            4'd0:    e.result = a + b;
            4'd1:    e.result = a - b;
            4'd2:    e.result = a & b;
            4'd3:    e.result = a | b;
            4'd4:    e.result = (sa < sb) ? 32'd1 : 32'd0;
            4'd5:    e.result = a ^ b;
            4'd6:    e.result = b >> sh;
            default: begin e.result = '0; e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    initial begin
        vecs[0]  = '{4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0};
        vecs[1]  = '{4'd1, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'h00F0_1200, 1'b0};
        vecs[3]  = '{4'd3, 32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F, 1'b0};
        vecs[4]  = '{4'd4, 32'hFFFF_FFFE, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0};
        vecs[5]  = '{4'd4, 32'h0000_0001, 32'hFFFF_FFFE, 5'd0,  32'h0000_0000, 1'b0};
        vecs[6]  = '{4'd4, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0};
        vecs[7]  = '{4'd5, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F, 1'b0};
        vecs[8]  = '{4'd6, 32'h1234_5678, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0};
        vecs[9]  = '{4'd6, 32'h0000_0000, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0};
        vecs[10] = '{4'd9, 32'h0000_0005, 32'h0000_0005, 5'd3,  32'h0000_0000, 1'b1};
        vecs[11] = '{4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1};
        vecs[12] = '{4'd15, 32'h0000_0001, 32'h0000_0002, 5'd1, 32'h0000_0000, 1'b1};

        // Reset state.
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_valid",   bus.out_valid,   1'b0);
        check("rst_in_ready",    bus.in_ready,    1'b1);
        check("rst_out_result",  bus.out_result,  32'd0);
        check("rst_out_zero",    bus.out_zero,    1'b1);
        check("rst_out_rd",      bus.out_rd,      5'd0);
        check("rst_out_illegal", bus.out_illegal, 1'b0);
        rst = 1'b0;

        // Single operations, one result per vector on the following cycle.
        bus.out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            offer(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sh, RW'(i));
            tick();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i),   bus.out_valid,   1'b1);
            check($sformatf("vec%0d_result", i),  bus.out_result,  vecs[i].res);
            check($sformatf("vec%0d_zero", i),    bus.out_zero,    vecs[i].res == 32'd0);
            check($sformatf("vec%0d_illegal", i), bus.out_illegal, vecs[i].ill);
            check($sformatf("vec%0d_rd", i),      bus.out_rd,      RW'(i));
            tick();
            check($sformatf("vec%0d_drained", i), bus.out_valid,   1'b0);
        end

        // Stall: rd 1 held, rd 2 in skid, rd 3 stalled; then ordered drain.
        bus.out_ready = 1'b0;
        offer(4'd0, 32'd10, 32'd0, 5'd0, 5'd1);
        tick();
        check("stall_rd1_out", bus.out_rd, 5'd1);
        check("stall_rdy_1",   bus.in_ready, 1'b1);
        offer(4'd0, 32'd20, 32'd0, 5'd0, 5'd2);
        tick();
        check("stall_rd1_hold", bus.out_rd, 5'd1);
        check("stall_rdy_0",    bus.in_ready, 1'b0);
        offer(4'd0, 32'd30, 32'd0, 5'd0, 5'd3);
        tick();
        tick();
        check("stall_rd1_still",  bus.out_rd,     5'd1);
        check("stall_res1_still", bus.out_result, 32'd10);
        check("stall_valid",      bus.out_valid,  1'b1);
        check("stall_op3_held",   bus.in_ready,   1'b0);
        bus.out_ready = 1'b1;
        tick();
        check("drain_rd2",       bus.out_rd,     5'd2);
        check("drain_res2",      bus.out_result, 32'd20);
        check("drain_rdy_rises", bus.in_ready,   1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("drain_rd3",   bus.out_rd,     5'd3);
        check("drain_res3",  bus.out_result, 32'd30);
        check("drain_valid", bus.out_valid,  1'b1);
        tick();
        check("drain_empty", bus.out_valid,  1'b0);

        // Flush with both entries full and an op offered in the flush cycle.
        bus.out_ready = 1'b0;
        offer(4'd0, 32'd1, 32'd0, 5'd0, 5'd1);
        tick();
        offer(4'd0, 32'd2, 32'd0, 5'd0, 5'd2);
        tick();
        offer(4'd0, 32'd7, 32'd0, 5'd0, 5'd7);
        bus.flush = 1'b1;
        #1;
        check("flush_same_cycle_valid", bus.out_valid, 1'b1);
        check("flush_same_cycle_rd",    bus.out_rd,    5'd1);
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("flush_valid", bus.out_valid, 1'b0);
        check("flush_ready", bus.in_ready,  1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("flush_no_rd7_%0d", i), bus.out_valid, 1'b0);
        end

        // Reset while stalled with both entries full.
        bus.out_ready = 1'b0;
        offer(4'd1, 32'd9, 32'd2, 5'd0, 5'd4);
        tick();
        offer(4'd1, 32'd9, 32'd3, 5'd0, 5'd5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("stall_rst_valid",   bus.out_valid,   1'b0);
        check("stall_rst_ready",   bus.in_ready,    1'b1);
        check("stall_rst_result",  bus.out_result,  32'd0);
        check("stall_rst_zero",    bus.out_zero,    1'b1);
        check("stall_rst_rd",      bus.out_rd,      5'd0);
        check("stall_rst_illegal", bus.out_illegal, 1'b0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_rst_quiet_%0d", i), bus.out_valid, 1'b0);
        end

        // Random traffic against the queue model: the stage holds at most two
        // results, accepts while it holds fewer than two, presents the oldest.
        model_q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [DW-1:0] ra;
            logic [DW-1:0] rb;
            logic          iv;
            logic          orr;
            logic          fl;
            logic          rs;
            logic          drain;
            logic          acc;
            ra  = $urandom();
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom();
            iv  = ($urandom_range(0, 9) < 7);
            orr = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 29) == 0);
            rs  = ($urandom_range(0, 99) == 0);
            offer(4'($urandom_range(0, 15)), ra, rb, 5'($urandom_range(0, 31)), RW'($urandom()));
            bus.in_valid  = iv;
            bus.out_ready = orr;
            bus.flush     = fl;
            rst           = rs;

            check("rand_in_ready", bus.in_ready,  model_q.size() < 2);
            check("rand_valid",    bus.out_valid, model_q.size() > 0);
            if (model_q.size() > 0) begin
                hd = model_q[0];
                check("rand_result",  bus.out_result,  hd.result);
                check("rand_zero",    bus.out_zero,    hd.result == '0);
                check("rand_illegal", bus.out_illegal, hd.illegal);
                check("rand_rd",      bus.out_rd,      hd.rd);
            end

            if (rs || fl) begin
                model_q.delete();
            end else begin
                drain = (model_q.size() > 0) && orr;
                acc   = iv && (model_q.size() < 2);
                if (drain) void'(model_q.pop_front());
                if (acc) model_q.push_back(alu_ref(bus.alu_sel, bus.op_a, bus.op_b, bus.shamt, bus.rd_in));
            end
            tick();
        end
        rst = 1'b0;
        bus.flush = 1'b0;
        check("rand_final_valid", bus.out_valid, model_q.size() > 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
